// File: rtl/req_ack_4ph_tx_buf_pkg.sv
// Shared types and constants for the buffered 4-phase request/acknowledge
// transmitter (req_ack_4ph_tx_buf) and its ack synchroniser.
package req_ack_pkg;

    // Handshake FSM states. IDLE: nothing in flight. REQ: req high, waiting
    // for ack to rise. WAIT_LO: req dropped, waiting for ack to return low.
    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_REQ     = 2'd1,
        HS_WAIT_LO = 2'd2
    } hs4_state_e;

    // Fewest flops allowed in the ack synchroniser chain.
    localparam int HS4_MIN_SYNC = 2;

endpackage

// File: rtl/req_ack_4ph_tx_buf_sync.sv
// hs4_sync_ff: multi-flop synchroniser bringing the asynchronous ack into
// the clk_tx domain. Chains shorter than HS4_MIN_SYNC are lengthened.
module hs4_sync_ff
    import req_ack_pkg::*;
#(
    parameter int NSYNC = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    localparam int NS = (NSYNC < HS4_MIN_SYNC) ? HS4_MIN_SYNC : NSYNC;

    logic [NS-1:0] chain_q;

    // Shift the raw input through the chain; clears to 0 on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[NS-2:0], d_i};
        end
    end

    assign q_o = chain_q[NS-1];

endmodule

// File: rtl/req_ack_4ph_tx_buf.sv
// req_ack_4ph_tx_buf: buffers words from a valid/ready upstream in a
// DEPTH-entry FIFO and sends each one across an asynchronous boundary with a
// return-to-zero 4-phase handshake (req up, ack up, req down, ack down).
// Optional build macro REQ_ACK_TIMEOUT_EN adds a sticky watchdog flag that
// rises when the receiver stops answering for TO_CYC cycles.
module req_ack_4ph_tx_buf
    import req_ack_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int NSYNC  = 2,
    parameter int TO_CYC = 256
) (
    input  logic                       clk_tx,
    input  logic                       rst_b,
    input  logic                       val,
    output logic                       rdy,
    input  logic [DW-1:0]              din,
    output logic                       req,
    input  logic                       ack,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy,
    input  logic                       err_clr,
    output logic                       timeout_err,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] ST_IDLE    = HS_IDLE;
    localparam logic [1:0] ST_REQ     = HS_REQ;
    localparam logic [1:0] ST_WAIT_LO = HS_WAIT_LO;

    // Upstream handshake: a word is accepted on a rising clk_tx edge exactly
    // when val and rdy are both high; din is sampled only then. rdy depends
    // only on registered occupancy (and reset), never on val.

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ack_s;
    logic          full, empty, push, pop;

    hs4_sync_ff #(.NSYNC(NSYNC)) u_ack_sync (
        .clk_i  (clk_tx),
        .rst_ni (rst_b),
        .d_i    (ack),
        .q_o    (ack_s)
    );

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign rdy   = rst_b & ~full;
    assign push  = val & rdy;

    // Handshake FSM: pops the FIFO head into dout whenever a new transfer starts.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dout_d  = dout_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !ack_s) begin
                    pop     = 1'b1;
                    dout_d  = mem_q[rd_ptr_q];
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!ack_s) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        dout_d  = mem_q[rd_ptr_q];
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer and occupancy next-state; a simultaneous push and pop leaves level alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_tx) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Control registers; reset discards buffered and in-flight words.
    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            dout_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            dout_q   <= dout_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef REQ_ACK_TIMEOUT_EN
    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [CW-1:0] to_cnt_q;
    logic          to_err_q;

    // Watchdog: counts cycles spent in one handshake state, flags at TO_CYC-1
    // and saturates; err_clr takes priority over everything else.
    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else if (err_clr) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else if (state_d != state_q) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT_LO) begin
            if (to_cnt_q == CW'(TO_CYC - 1)) begin
                to_err_q <= 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q + CW'(1);
            end
        end
    end

    assign timeout_err = to_err_q;
`else
    logic unused_err_clr;
    logic [31:0] unused_to_cyc;
    assign unused_err_clr = err_clr;
    assign unused_to_cyc  = TO_CYC;
    assign timeout_err    = 1'b0;
`endif

    assign req       = req_q;
    assign dout      = dout_q;
    assign level     = level_q;
    assign busy      = (state_q != ST_IDLE) | (level_q != '0);
    assign dbg_state = state_q;

endmodule
